fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Parametrised multi-entry bundle queue between Fetch-2 and Decode; replaces the single-stage Fetch2Decode latch.
- Holds up to DEPTH fetch bundles, each FETCH_WIDTH lanes wide, with valid/stall handshakes on both sides.
- Applies per-lane active masking at enqueue. Drops bundles with no surviving lanes. Flushes on recovery, exception or fetch reset.

Parameters:
- FETCH_WIDTH, 4: lanes per bundle.
- PKT_W, 64: bits per flattened lane decode packet.
- DEPTH, 2: bundle entries; power of 2, >= 2.
- CNT_W, $clog2(DEPTH+1): occupancy counter width (derived).

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- flush_i, input, 1: OR of recover, exception and resetFetch.
- laneActive_i, input, FETCH_WIDTH: dynamic-config lane enable mask.
- bundleValid_i, input, 1: Fetch-2 presents a bundle.
- laneValid_i, input, FETCH_WIDTH: per-lane valid bits of the incoming bundle.
- decPacket_i, input, FETCH_WIDTH*PKT_W: lane packets; lane 0 in the LSBs.
- ready_o, output, 1: queue can accept (drives fs2Ready to Fetch).
- stall_i, input, 1: downstream stall (instBufferFull | ctiQueueFull).
- bundleValid_o, output, 1: head bundle valid toward Decode.
- laneValid_o, output, FETCH_WIDTH: head lane valids.
- decPacket_o, output, FETCH_WIDTH*PKT_W: head lane packets.
- count_o, output, CNT_W: current occupancy.

Behaviour:
- Reset (async assert, sync release): head=tail=0, count=0, all storage valid bits 0.
  - Outputs after reset: ready_o=1, bundleValid_o=0, laneValid_o=0, decPacket_o=0, count_o=0.
- ready_o = (count < DEPTH) & ~flush_i; combinational from registered count.
- Effective lane mask: m = laneValid_i & laneActive_i.
- Enqueue: bundleValid_i & ready_o & (|m).
  - Writes m and decPacket_i into entry[tail]; tail advances by 1 modulo DEPTH.
  - Packets of masked-off lanes are stored as 0.
  - bundleValid_i with m==0 is consumed and discarded: nothing is written, the handshake is still acknowledged, count is unchanged.
- Dequeue: bundleValid_o & ~stall_i; head advances by 1 modulo DEPTH.
- bundleValid_o = (count != 0).
- laneValid_o and decPacket_o come combinationally from entry[head]; both are forced to 0 when count==0.
- Latency: a bundle enqueued in cycle N is visible at the output in cycle N+1 at the earliest. There is no same-cycle bypass.
- Count update: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Full (count==DEPTH): ready_o=0 even if a dequeue happens in the same cycle. No enqueue-on-full pass-through; ready_o rises the cycle after the dequeue.
- Empty: a stall_i assertion has no effect.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0; fullness is decided by count, not by pointer equality.
- Flush (synchronous, highest priority):
  - head=tail=0 and count=0 on the next edge.
  - Any same-cycle enqueue or dequeue is ignored.
  - bundleValid_o=0 in the following cycle.
- Stall holds the head entry and its outputs stable; enqueues continue while not full.
- laneActive_i changes affect only future enqueues; bundles already stored keep their captured masks.
- Async reset asserted mid-operation clears all state immediately, independent of clk.

Optional Feature:
- Macro: FDQ_STALL_STATS_EN.
- When defined:
  - Adds output stallCycles_o (32 bits): increments every cycle where bundleValid_o & stall_i, and saturates at 0xFFFFFFFF.
  - Adds output fullCycles_o (32 bits): increments every cycle where count==DEPTH, and saturates.
  - Both counters clear on reset only; flush does not clear them.
- When undefined: these ports and the counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then single enqueue with laneValid_i=4'b1111, laneActive_i=4'b1111, stall_i=0 -> bundleValid_o=1 next cycle with matching packets; count_o goes 1 then 0; ready_o stays 1.
- DEPTH=2, stall_i=1, three back-to-back bundles A, B, C -> A and B accepted; ready_o=0 with C held; count_o=2. Release stall -> outputs A then B in order; C accepted the cycle after ready_o returns to 1.
- laneValid_i=4'b1011, laneActive_i=4'b0011 -> laneValid_o=4'b0011, lane 3 packet =0. Then laneValid_i=4'b1100, laneActive_i=4'b0011 -> bundle dropped, count_o unchanged, ready_o=1.
- Full queue, flush_i=1 in the same cycle as bundleValid_i and ~stall_i -> next cycle count_o=0, bundleValid_o=0, decPacket_o=0; the flushed-cycle input never appears at the output.
- 10 enqueue/dequeue pairs with DEPTH=4 (pointer wrap), then async reset pulsed mid-cycle with count=3 -> outputs return to reset values immediately; normal operation resumes after release.
- FDQ_STALL_STATS_EN defined, 5 stalled cycles with a valid head -> stallCycles_o=5. fullCycles_o counts only cycles with count==DEPTH. Flush leaves both counters unchanged.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
// Multi-entry bundle queue between Fetch-2 and Decode. Incoming bundles are
// masked per lane (laneValid_i & laneActive_i) on entry; a bundle with no
// surviving lane is acknowledged but not stored. The head entry drives the
// Decode-side outputs combinationally, so a stored bundle is visible one
// cycle after its enqueue. Fullness is tracked by an occupancy counter,
// not by pointer equality. A flush empties the queue on the next edge.
//
// Optional build macro: FDQ_STALL_STATS_EN
//   Adds saturating 32-bit counters stallCycles_o and fullCycles_o.
//   Only reset clears them; a flush leaves them unchanged.
module fetch_decode_queue #(
  parameter int FETCH_WIDTH = 4,
  parameter int PKT_W       = 64,
  parameter int DEPTH       = 2,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic [FETCH_WIDTH-1:0]       laneActive_i,
  input  logic                         bundleValid_i,
  input  logic [FETCH_WIDTH-1:0]       laneValid_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0] decPacket_i,
  output logic                         ready_o,
  input  logic                         stall_i,
  output logic                         bundleValid_o,
  output logic [FETCH_WIDTH-1:0]       laneValid_o,
  output logic [FETCH_WIDTH*PKT_W-1:0] decPacket_o,
  output logic [CNT_W-1:0]             count_o
`ifdef FDQ_STALL_STATS_EN
  ,
  output logic [31:0]                  stallCycles_o,
  output logic [31:0]                  fullCycles_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int BUS_W = FETCH_WIDTH * PKT_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Queue state
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;
  logic [FETCH_WIDTH-1:0] r_lane_mask [DEPTH];
  logic [BUS_W-1:0]       r_pkt       [DEPTH];

  // Handshake and datapath nets
  logic [FETCH_WIDTH-1:0] w_mask;
  logic [BUS_W-1:0]       w_masked_pkt;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_ready;
  logic                   w_enq;
  logic                   w_deq;

  assign w_mask  = laneValid_i & laneActive_i;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // Full blocks acceptance even when the head leaves this cycle: there is
  // deliberately no enqueue-on-full pass-through.
  assign w_ready = (r_count < DEPTH_C) & ~flush_i;

  // A bundle whose lanes are all masked off is acknowledged via w_ready but
  // never written, so it does not consume an entry.
  assign w_enq = bundleValid_i & w_ready & (|w_mask);
  assign w_deq = ~w_empty & ~stall_i;

  // Zero the packets of masked-off lanes so Decode never sees stale data.
  generate
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane_mask
      assign w_masked_pkt[gi*PKT_W +: PKT_W] =
        w_mask[gi] ? decPacket_i[gi*PKT_W +: PKT_W] : '0;
    end
  endgenerate

  // Head/tail pointers and occupancy; flush overrides any same-cycle enq/deq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_deq) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Per-entry lane masks; cleared by reset so no entry looks valid afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_lane_mask[i] <= '0;
      end
    end else if (w_enq) begin
      r_lane_mask[r_tail] <= w_mask;
    end
  end

  // Packet payload storage; only read while its entry is occupied.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pkt[r_tail] <= w_masked_pkt;
    end
  end

  assign ready_o       = w_ready;
  assign bundleValid_o = ~w_empty;
  assign laneValid_o   = w_empty ? '0 : r_lane_mask[r_head];
  assign decPacket_o   = w_empty ? '0 : r_pkt[r_head];
  assign count_o       = r_count;

`ifdef FDQ_STALL_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_full_cycles;

  // Saturating count of cycles where a valid head is held by a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (~w_empty && stall_i && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  // Saturating count of cycles spent completely full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full_cycles <= '0;
    end else if (w_full && (r_full_cycles != 32'hFFFF_FFFF)) begin
      r_full_cycles <= r_full_cycles + 32'd1;
    end
  end

  assign stallCycles_o = r_stall_cycles;
  assign fullCycles_o  = r_full_cycles;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Testbench for fetch_decode_queue (DEPTH=4 instance). Directed scenarios
// use constants taken from the queue's rules; the random scenario checks
// against a queue-of-bundles reference model.
module tb_fetch_decode_queue;

  localparam int FW = 4;
  localparam int PW = 64;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);
  localparam int BW = FW * PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_i;
  logic [FW-1:0] laneActive_i;
  logic          bundleValid_i;
  logic [FW-1:0] laneValid_i;
  logic [BW-1:0] decPacket_i;
  logic          ready_o;
  logic          stall_i;
  logic          bundleValid_o;
  logic [FW-1:0] laneValid_o;
  logic [BW-1:0] decPacket_o;
  logic [CW-1:0] count_o;
`ifdef FDQ_STALL_STATS_EN
  logic [31:0]   stallCycles_o;
  logic [31:0]   fullCycles_o;
`endif

  always #5 clk = ~clk;

  fetch_decode_queue #(
    .FETCH_WIDTH(FW),
    .PKT_W(PW),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush_i(flush_i),
    .laneActive_i(laneActive_i),
    .bundleValid_i(bundleValid_i),
    .laneValid_i(laneValid_i),
    .decPacket_i(decPacket_i),
    .ready_o(ready_o),
    .stall_i(stall_i),
    .bundleValid_o(bundleValid_o),
    .laneValid_o(laneValid_o),
    .decPacket_o(decPacket_o),
    .count_o(count_o)
`ifdef FDQ_STALL_STATS_EN
    ,
    .stallCycles_o(stallCycles_o),
    .fullCycles_o(fullCycles_o)
`endif
  );

  typedef struct packed {
    logic [FW-1:0] m;
    logic [BW-1:0] p;
  } bundle_t;

  bundle_t     mq[$];
  int unsigned m_stall = 0;
  int unsigned m_full  = 0;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [BW-1:0] mask_pkt(input logic [FW-1:0] m, input logic [BW-1:0] p);
    logic [BW-1:0] r;
    r = '0;
    for (int l = 0; l < FW; l++) if (m[l]) r[l*PW +: PW] = p[l*PW +: PW];
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_pkt();
    logic [BW-1:0] r;
    for (int k = 0; k < BW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input logic fl, input logic bv, input logic [FW-1:0] lv,
                       input logic [FW-1:0] la, input logic [BW-1:0] pk, input logic st);
    flush_i       = fl;
    bundleValid_i = bv;
    laneValid_i   = lv;
    laneActive_i  = la;
    decPacket_i   = pk;
    stall_i       = st;
  endtask

  // Advance one clock and update the reference model from the inputs seen at the edge.
  task automatic step();
    logic [FW-1:0] m;
    bit full, hv, rdy;
    bundle_t b;
    @(posedge clk);
    m    = laneValid_i & laneActive_i;
    full = (mq.size() == D);
    hv   = (mq.size() != 0);
    rdy  = !full && !flush_i;
    if (reset) begin
      mq.delete();
      m_stall = 0;
      m_full  = 0;
    end else begin
      if (hv && stall_i) m_stall++;
      if (full) m_full++;
      if (flush_i) begin
        mq.delete();
        $display("[%0t] flush", $time);
      end else begin
        if (hv && !stall_i) begin
          $display("[%0t] deq mask=%b", $time, mq[0].m);
          mq.delete(0);
        end
        if (bundleValid_i && rdy) begin
          if (m != '0) begin
            b.m = m;
            b.p = mask_pkt(m, decPacket_i);
            mq.push_back(b);
            $display("[%0t] enq mask=%b", $time, m);
          end else begin
            $display("[%0t] drop (empty mask)", $time);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++; if (bundleValid_o !== 1'b0) begin failures++; $display("FAIL reset_bv got=%b exp=0", bundleValid_o); end
    checks++; if (laneValid_o !== '0) begin failures++; $display("FAIL reset_lv got=%b exp=0", laneValid_o); end
    checks++; if (decPacket_o !== '0) begin failures++; $display("FAIL reset_pkt got=%h exp=0", decPacket_o); end
    checks++; if (count_o !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_single();
    logic [BW-1:0] pa;
    pa = rand_pkt();
    drive(0, 1, 4'b1111, 4'b1111, pa, 0);
    #1;
    checks++; if (bundleValid_o !== 1'b0) begin failures++; $display("FAIL single_nobypass got=%b exp=0", bundleValid_o); end
    step();
    drive(0, 0, 4'b0000, 4'b1111, '0, 0);
    #1;
    checks++; if (bundleValid_o !== 1'b1) begin failures++; $display("FAIL single_bv got=%b exp=1", bundleValid_o); end
    checks++; if (laneValid_o !== 4'b1111) begin failures++; $display("FAIL single_lv got=%b exp=1111", laneValid_o); end
    checks++; if (decPacket_o !== pa) begin failures++; $display("FAIL single_pkt got=%h exp=%h", decPacket_o, pa); end
    checks++; if (count_o !== CW'(1)) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", ready_o); end
    step();
    #1;
    checks++; if (count_o !== '0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", count_o); end
    checks++; if (bundleValid_o !== 1'b0) begin failures++; $display("FAIL single_bv0 got=%b exp=0", bundleValid_o); end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] b [D+1];
    for (int i = 0; i <= D; i++) b[i] = rand_pkt();
    for (int i = 0; i < D; i++) begin
      drive(0, 1, 4'b1111, 4'b1111, b[i], 1);
      #1;
      checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_fill%0d got=%b exp=1", i, ready_o); end
      step();
    end
    drive(0, 1, 4'b1111, 4'b1111, b[D], 1);
    #1;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%b exp=0", ready_o); end
    checks++; if (count_o !== CW'(D)) begin failures++; $display("FAIL b2b_count_full got=%0d exp=%0d", count_o, D); end
    checks++; if (decPacket_o !== b[0]) begin failures++; $display("FAIL b2b_head_stall got=%h exp=%h", decPacket_o, b[0]); end
    step();
    #1;
    checks++; if (count_o !== CW'(D)) begin failures++; $display("FAIL b2b_count_held got=%0d exp=%0d", count_o, D); end
    stall_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL b2b_ready_deqfull got=%b exp=0", ready_o); end
    checks++; if (decPacket_o !== b[0]) begin failures++; $display("FAIL b2b_out0 got=%h exp=%h", decPacket_o, b[0]); end
    step();
    #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_back got=%b exp=1", ready_o); end
    checks++; if (count_o !== CW'(D-1)) begin failures++; $display("FAIL b2b_count_after got=%0d exp=%0d", count_o, D-1); end
    checks++; if (decPacket_o !== b[1]) begin failures++; $display("FAIL b2b_out1 got=%h exp=%h", decPacket_o, b[1]); end
    step();
    drive(0, 0, 4'b0000, 4'b1111, '0, 0);
    for (int j = 2; j <= D; j++) begin
      #1;
      checks++; if (decPacket_o !== b[j]) begin failures++; $display("FAIL b2b_out%0d got=%h exp=%h", j, decPacket_o, b[j]); end
      step();
    end
    #1;
    checks++; if (count_o !== '0) begin failures++; $display("FAIL b2b_drained got=%0d exp=0", count_o); end
  endtask

  task automatic test_mask();
    logic [BW-1:0] p, q, exp_p;
    p = rand_pkt();
    q = rand_pkt();
    exp_p = p;
    exp_p[BW-1:2*PW] = '0;
    drive(0, 1, 4'b1011, 4'b0011, p, 1);
    step();
    drive(0, 1, 4'b1100, 4'b0011, q, 1);
    #1;
    checks++; if (laneValid_o !== 4'b0011) begin failures++; $display("FAIL mask_lv got=%b exp=0011", laneValid_o); end
    checks++; if (decPacket_o !== exp_p) begin failures++; $display("FAIL mask_pkt got=%h exp=%h", decPacket_o, exp_p); end
    checks++; if (decPacket_o[3*PW +: PW] !== '0) begin failures++; $display("FAIL mask_lane3 got=%h exp=0", decPacket_o[3*PW +: PW]); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL mask_drop_ready got=%b exp=1", ready_o); end
    step();
    drive(0, 0, 4'b0000, 4'b1111, '0, 1);
    #1;
    checks++; if (count_o !== CW'(1)) begin failures++; $display("FAIL mask_drop_count got=%0d exp=1", count_o); end
    checks++; if (laneValid_o !== 4'b0011) begin failures++; $display("FAIL mask_kept_lv got=%b exp=0011", laneValid_o); end
    stall_i = 1'b0;
    step();
    #1;
    checks++; if (count_o !== '0) begin failures++; $display("FAIL mask_drain got=%0d exp=0", count_o); end
  endtask

  task automatic test_flush();
    logic [BW-1:0] c;
    for (int i = 0; i < D; i++) begin
      drive(0, 1, 4'b1111, 4'b1111, rand_pkt(), 1);
      step();
    end
    c = rand_pkt();
    drive(1, 1, 4'b1111, 4'b1111, c, 0);
    #1;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", ready_o); end
    step();
    drive(0, 0, 4'b0000, 4'b1111, '0, 0);
    #1;
    checks++; if (count_o !== '0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    checks++; if (bundleValid_o !== 1'b0) begin failures++; $display("FAIL flush_bv got=%b exp=0", bundleValid_o); end
    checks++; if (decPacket_o !== '0) begin failures++; $display("FAIL flush_pkt got=%h exp=0", decPacket_o); end
    step();
    #1;
    checks++; if (bundleValid_o !== 1'b0) begin failures++; $display("FAIL flush_noleak got=%b exp=0", bundleValid_o); end
  endtask

  task automatic test_random();
    logic [FW-1:0] exp_lv;
    logic [BW-1:0] exp_pkt;
    bit exp_bv, exp_rdy;
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), FW'($urandom),
            ($urandom_range(0, 3) == 0) ? FW'($urandom) : 4'b1111, rand_pkt(),
            ($urandom_range(0, 2) == 0));
      #1;
      exp_bv  = (mq.size() != 0);
      exp_rdy = (mq.size() < D) && !flush_i;
      exp_lv  = exp_bv ? mq[0].m : '0;
      exp_pkt = exp_bv ? mq[0].p : '0;
      checks++; if (ready_o !== exp_rdy) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, ready_o, exp_rdy); end
      checks++; if (bundleValid_o !== exp_bv) begin failures++; $display("FAIL rnd_bv n=%0d got=%b exp=%b", n, bundleValid_o, exp_bv); end
      checks++; if (count_o !== CW'(mq.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count_o, mq.size()); end
      checks++; if (laneValid_o !== exp_lv) begin failures++; $display("FAIL rnd_lv n=%0d got=%b exp=%b", n, laneValid_o, exp_lv); end
      checks++; if (decPacket_o !== exp_pkt) begin failures++; $display("FAIL rnd_pkt n=%0d got=%h exp=%h", n, decPacket_o, exp_pkt); end
      step();
    end
    drive(1, 0, 4'b0000, 4'b1111, '0, 0);
    step();
  endtask

  task automatic test_wrap_async_reset();
    logic [BW-1:0] prev, cur, z;
    prev = '0;
    for (int k = 0; k < 10; k++) begin
      cur = rand_pkt();
      drive(0, 1, 4'b1111, 4'b1111, cur, 0);
      #1;
      if (k > 0) begin
        checks++; if (decPacket_o !== prev) begin failures++; $display("FAIL wrap_out%0d got=%h exp=%h", k, decPacket_o, prev); end
        checks++; if (count_o !== CW'(1)) begin failures++; $display("FAIL wrap_count%0d got=%0d exp=1", k, count_o); end
      end
      step();
      prev = cur;
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 4'b1111, 4'b1111, rand_pkt(), 1);
      step();
    end
    drive(0, 0, 4'b0000, 4'b1111, '0, 1);
    #1;
    checks++; if (count_o !== CW'(3)) begin failures++; $display("FAIL wrap_count3 got=%0d exp=3", count_o); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (count_o !== '0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count_o); end
    checks++; if (bundleValid_o !== 1'b0) begin failures++; $display("FAIL areset_bv got=%b exp=0", bundleValid_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL areset_ready got=%b exp=1", ready_o); end
    checks++; if (decPacket_o !== '0) begin failures++; $display("FAIL areset_pkt got=%h exp=0", decPacket_o); end
    step();
    reset = 1'b0;
    z = rand_pkt();
    drive(0, 1, 4'b0110, 4'b1111, z, 0);
    step();
    drive(0, 0, 4'b0000, 4'b1111, '0, 0);
    #1;
    checks++; if (count_o !== CW'(1)) begin failures++; $display("FAIL resume_count got=%0d exp=1", count_o); end
    checks++; if (decPacket_o !== mask_pkt(4'b0110, z)) begin failures++; $display("FAIL resume_pkt got=%h exp=%h", decPacket_o, mask_pkt(4'b0110, z)); end
    step();
  endtask

`ifdef FDQ_STALL_STATS_EN
  task automatic test_stall_stats();
    reset = 1'b1;
    drive(0, 0, 4'b0000, 4'b1111, '0, 0);
    step();
    reset = 1'b0;
    drive(0, 1, 4'b1111, 4'b1111, rand_pkt(), 1);
    step();
    drive(0, 0, 4'b0000, 4'b1111, '0, 1);
    for (int i = 0; i < 5; i++) step();
    #1;
    checks++; if (stallCycles_o !== 32'd5) begin failures++; $display("FAIL stats_stall5 got=%0d exp=5", stallCycles_o); end
    checks++; if (fullCycles_o !== 32'd0) begin failures++; $display("FAIL stats_full0 got=%0d exp=0", fullCycles_o); end
    for (int i = 0; i < D + 2; i++) begin
      drive(0, 1, 4'b1111, 4'b1111, rand_pkt(), 1);
      step();
    end
    #1;
    checks++; if (stallCycles_o !== m_stall) begin failures++; $display("FAIL stats_stall got=%0d exp=%0d", stallCycles_o, m_stall); end
    checks++; if (fullCycles_o !== m_full) begin failures++; $display("FAIL stats_full got=%0d exp=%0d", fullCycles_o, m_full); end
    drive(1, 0, 4'b0000, 4'b1111, '0, 1);
    step();
    drive(0, 0, 4'b0000, 4'b1111, '0, 0);
    #1;
    checks++; if (stallCycles_o !== m_stall) begin failures++; $display("FAIL stats_flush_stall got=%0d exp=%0d", stallCycles_o, m_stall); end
    checks++; if (fullCycles_o !== m_full) begin failures++; $display("FAIL stats_flush_full got=%0d exp=%0d", fullCycles_o, m_full); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive(0, 0, 4'b0000, 4'b1111, '0, 0);
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_single();
    test_back_to_back();
    test_mask();
    test_flush();
    test_random();
    test_wrap_async_reset();
`ifdef FDQ_STALL_STATS_EN
    test_stall_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
